// File: rtl/pulse_arbiter.sv
// Round-robin owner of a shared pulsegen: grants one requester at a time, counts
// the returned pulse edges and releases on burst completion, timeout or request drop.
module pulse_arbiter #(
    parameter int                   TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = TIMEOUT_W'(4_000_000)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [7:0]  req_mode,
    input  logic [15:0] req_len,
    input  logic        gen_pulse,
    output logic        gen_start,
    output logic [1:0]  gen_mode,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [3:0]  err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

    state_t               state, state_n;
    logic [1:0]           ptr, ptr_n, owner, owner_n, win, cand;
    logic                 found;
    logic [3:0]           len_q, len_n, cnt, cnt_n;
    logic [TIMEOUT_W-1:0] wd, wd_n;
    logic                 gen_pulse_d, pulse_edge, final_edge, abort;
    logic                 start_n;
    logic [1:0]           mode_n;
    logic [3:0]           grant_n, done_n, err_n;

    assign pulse_edge = gen_pulse & ~gen_pulse_d;
    assign final_edge = pulse_edge && ((cnt + 4'd1) == len_q);
    // The watchdog holds cycles elapsed since the last clear point, so it expires one short of TIMEOUT.
    assign abort      = (!pulse_edge && (wd == TIMEOUT - TIMEOUT_W'(1))) || !req[owner];
    assign busy       = (state != IDLE);

    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        len_n   = len_q;
        cnt_n   = cnt;
        wd_n    = wd;
        start_n = gen_start;
        mode_n  = gen_mode;
        grant_n = grant;
        done_n  = '0;
        err_n   = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_n = win;
                    ptr_n   = win + 2'd1;
                    len_n   = req_len[4*win +: 4];
                    grant_n = 4'b0001 << win;
                    cnt_n   = '0;
                    wd_n    = TIMEOUT_W'(1);
                    if (req_len[4*win +: 4] == 4'd0) begin
                        done_n  = 4'b0001 << win;
                        state_n = GAP;
                    end else begin
                        start_n = 1'b1;
                        mode_n  = req_mode[2*win +: 2];
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (final_edge) begin
                    done_n  = grant;
                    start_n = 1'b0;
                    grant_n = '0;
                    state_n = GAP;
                end else if (abort) begin
                    err_n   = grant;
                    start_n = 1'b0;
                    grant_n = '0;
                    state_n = GAP;
                end else if (pulse_edge) begin
                    cnt_n = cnt + 4'd1;
                    wd_n  = TIMEOUT_W'(1);
                end else begin
                    wd_n = wd + TIMEOUT_W'(1);
                end
            end
            GAP: begin
                grant_n = '0;
                start_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            len_q       <= '0;
            cnt         <= '0;
            wd          <= '0;
            gen_pulse_d <= 1'b0;
            gen_start   <= 1'b0;
            gen_mode    <= '0;
            grant       <= '0;
            done        <= '0;
            err         <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            len_q       <= len_n;
            cnt         <= cnt_n;
            wd          <= wd_n;
            gen_pulse_d <= gen_pulse;
            gen_start   <= start_n;
            gen_mode    <= mode_n;
            grant       <= grant_n;
            done        <= done_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_pulse_arbiter.sv
// Self-checking bench for pulse_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a cycle-stamp behavioural model.
module tb_pulse_arbiter;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  req_mode = '0;
    logic [15:0] req_len = '0;
    logic        gen_pulse = 1'b0;
    logic        gen_start, busy;
    logic [1:0]  gen_mode;
    logic [3:0]  grant, done, err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    pulse_arbiter #(.TIMEOUT_W(24), .TIMEOUT(24'd20)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mode(req_mode), .req_len(req_len),
        .gen_pulse(gen_pulse), .gen_start(gen_start), .gen_mode(gen_mode),
        .grant(grant), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner/phase bookkeeping with cycle timestamps for the watchdog.
    int         m_phase = 0;  // 0 idle, 1 bursting, 2 gap
    int         rr = 0, owner = 0, mlen = 0, pulses = 0, clear_cyc = 0, cyc = 0, winner;
    logic       prev_pulse = 1'b0;
    bit         edge_seen;
    logic [3:0] e_grant = '0, e_done = '0, e_err = '0;
    logic       e_start = 1'b0;
    logic [1:0] e_mode = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; rr = 0; owner = 0; mlen = 0; pulses = 0; clear_cyc = 0;
            prev_pulse = 1'b0;
            e_grant = '0; e_done = '0; e_err = '0; e_start = 1'b0; e_mode = '0;
        end else begin
            cyc++;
            edge_seen  = gen_pulse && !prev_pulse;
            prev_pulse = gen_pulse;
            e_done = '0;
            e_err  = '0;
            case (m_phase)
                0: begin
                    winner = -1;
                    for (int k = 0; k < 4; k++)
                        if (winner < 0 && req[(rr + k) % 4]) winner = (rr + k) % 4;
                    if (winner >= 0) begin
                        owner     = winner;
                        rr        = (winner + 1) % 4;
                        mlen      = int'(req_len[4*winner +: 4]);
                        pulses    = 0;
                        clear_cyc = cyc - 1;
                        e_grant   = 4'(1 << winner);
                        if (mlen == 0) begin
                            e_done  = e_grant;
                            m_phase = 2;
                        end else begin
                            e_start = 1'b1;
                            e_mode  = req_mode[2*winner +: 2];
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (edge_seen) pulses++;
                    if (edge_seen && pulses == mlen) e_done = e_grant;
                    else if (!req[owner] || (!edge_seen && (cyc - clear_cyc) >= TMO)) e_err = e_grant;
                    else if (edge_seen) clear_cyc = cyc - 1;
                    if (e_done != 0 || e_err != 0) begin
                        e_grant = '0;
                        e_start = 1'b0;
                        m_phase = 2;
                    end
                end
                default: begin
                    e_grant = '0;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("cycle_outputs", {grant, done, err, gen_start, gen_mode, busy},
                  {e_grant, e_done, e_err, e_start, e_mode, m_phase != 0});
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        end
    end

    task automatic wait_grant();
        int n = 0;
        while (grant == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", 32'(grant != 4'b0), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic pulse_once();
        @(negedge clk) gen_pulse = 1'b1;
        @(negedge clk) gen_pulse = 1'b0;
    endtask

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        // Reset with every requester asking
        req = 4'b1111; req_len = 16'h1111;
        repeat (3) @(negedge clk);
        check("reset_outputs", {grant, done, err, gen_start, gen_mode, busy}, 32'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_release_grant", grant, 4'b0001);

        // Round-robin over four len-1 bursts
        for (int k = 0; k < 5; k++) begin
            wait_grant();
            check($sformatf("rr_order_%0d", k), grant, rr_exp[k]);
            pulse_once();
        end
        req = 4'b0000;
        wait_idle();

        // Single burst, requester 2, mode 10, len 3
        req_mode = 8'b0010_0000; req_len = 16'h0300; req = 4'b0100;
        wait_grant();
        check("burst_mode", gen_mode, 2'b10);
        check("burst_start", gen_start, 1'b1);
        pulse_once(); @(negedge clk);
        pulse_once(); @(negedge clk);
        pulse_once();
        check("burst_done", done, 4'b0100);
        check("burst_gap_start0", gen_start, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        check("burst_gap_start1", gen_start, 1'b0);
        wait_idle();

        // Zero-length burst for requester 1
        req_len = 16'h0000; req = 4'b0010;
        wait_grant();
        check("len0_grant", grant, 4'b0010);
        check("len0_done", done, 4'b0010);
        check("len0_no_start", gen_start, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        check("len0_grant_drop", grant, 4'b0000);
        wait_idle();

        // Watchdog: one pulse of two, then silence
        req_len = 16'h0002; req = 4'b0001;
        wait_grant();
        pulse_once();
        repeat (18) @(negedge clk);
        check("timeout_not_early", err, 4'b0000);
        @(negedge clk);
        check("timeout_err", err, 4'b0001);
        check("timeout_gap", {grant, busy}, {4'b0000, 1'b1});
        req = 4'b0000;
        @(negedge clk);
        check("timeout_idle", busy, 1'b0);

        // Request drop mid-burst
        req_len = 16'h5000; req = 4'b1000;
        wait_grant();
        pulse_once();
        @(negedge clk) req = 4'b0000;
        @(negedge clk);
        check("drop_err", err, 4'b1000);
        wait_idle();

        // Final edge in the same cycle as the request drop
        req_len = 16'h0001; req = 4'b0001;
        wait_grant();
        @(negedge clk);
        gen_pulse = 1'b1; req = 4'b0000;
        @(negedge clk);
        check("race_done", done, 4'b0001);
        check("race_no_err", err, 4'b0000);
        gen_pulse = 1'b0;
        wait_idle();

        // Reset pulsed mid-burst
        req_len = 16'h0040; req = 4'b0010;
        wait_grant();
        pulse_once();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midreset_outputs", {grant, done, err, gen_start, gen_mode, busy}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check("midreset_no_strobe", {done, err}, 8'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(15) == 0) req[b] = ~req[b];
            req_mode  = 8'($urandom);
            req_len   = 16'($urandom);
            gen_pulse = ($urandom_range(9) < 4);
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_arbiter.md
# pulse_arbiter

Round-robin scheduler that shares the single `pulsegen` instance among four requesters. Each requester asks for a burst of pulses in a chosen mode. The arbiter grants one requester at a time, drives the generator's `start`/`mode`, and counts the returned pulses. When the burst is complete, or a timeout fires, it stops the generator and moves on to the next requester. It sits between the lab's control logic and `pulsegen`, on the same clock.

## Interface
Parameters:
- `TIMEOUT_W`, 24: width of the per-pulse watchdog counter.
- `TIMEOUT`, 24'd4_000_000: max cycles allowed between grant/previous pulse edge and the next pulse edge.

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  per-requester request level; bit i = requester i.
- `req_mode`  in  8  2-bit mode per requester; `req_mode[2i+1:2i]`.
- `req_len`  in  16  4-bit burst length per requester; `req_len[4i+3:4i]`, range 0..15.
- `gen_pulse`  in  1  `pulse` output of `pulsegen`.
- `gen_start`  out  1  drives `pulsegen.start`.
- `gen_mode`  out  2  drives `pulsegen.mode`.
- `grant`  out  4  one-hot owner of the generator; 0 when idle.
- `done`  out  4  1-cycle strobe: burst completed for requester i.
- `err`  out  4  1-cycle strobe: burst aborted for requester i, by timeout or by `req` dropping.
- `busy`  out  1  high in RUN and GAP.

## Operation
- Reset values: all outputs 0. State is IDLE, round-robin pointer is 0, counters are 0, `gen_pulse` history register is 0.
- States: IDLE, RUN, GAP.
- IDLE arbitration:
  - Pick the first set `req` bit, searching from the pointer upward with wrap 3→0.
  - Latch that requester's mode and len, and set `grant`.
  - Set the pointer to the winner + 1 (mod 4).
  - If `req` is 0, stay in IDLE.
- IDLE with winner len = 0: no `gen_start`. Strobe `done[i]` next cycle with `grant` high for that single cycle, then go to GAP.
- IDLE with winner len ≠ 0: go to RUN, assert `gen_start` = 1 and drive `gen_mode` with the latched mode.
- RUN:
  - Edge detect: `gen_pulse & ~gen_pulse_d` counts one pulse; no synchronizer.
  - `gen_mode` and the latched len stay frozen for the whole burst; changes to `req_mode`/`req_len` during RUN are ignored.
  - When the pulse count equals len: strobe `done[i]`, drop `gen_start` and `grant`, go to GAP.
- Watchdog:
  - Cleared on entry to RUN and on every counted edge; increments otherwise.
  - Reaching `TIMEOUT` → strobe `err[i]`, drop `gen_start`/`grant`, go to GAP.
- Requester drops `req[i]` while owning the generator → same abort path as timeout (`err[i]`).
- Simultaneous events in the same cycle:
  - Final edge together with timeout → `done` wins.
  - Final edge together with `req` drop → `done` wins.
- GAP: exactly 1 cycle with `gen_start` = 0. This guarantees that `pulsegen` sees `start` low and clears `pulse`/`counter` before the next owner. Then go to IDLE.
- `gen_mode` holds its last value outside RUN.
- `rst_n` asserted mid-burst → immediate return to reset values. No `done`/`err` is issued.

## Timing
- `req` is sampled in IDLE at cycle T; `grant` and `gen_start` go high at T+1.
- The final counted edge is sampled at cycle E. At E+1: `done` is high, `gen_start` and `grant` are 0, state is GAP. E+2 is IDLE; the next grant appears at E+3.
- `gen_start` is low for at least 2 cycles between bursts.
- Timeout: `err` rises exactly `TIMEOUT` cycles after the last clear point.
- `done` and `err` are mutually exclusive and last exactly 1 cycle. At most one bit is set per cycle.
- `grant` is always one-hot or zero.

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 4'b1111 → all outputs 0. Release → `grant` = 4'b0001 two cycles after release.
- Single burst: `req` = 4'b0100, mode 2'b10, len 3; drive 3 `gen_pulse` pulses → `gen_mode` = 2'b10. `done` = 4'b0100 one cycle after the 3rd rising edge, then `gen_start` = 0 for 2 cycles.
- Round-robin: `req` = 4'b1111 held, all len 1 → grant order 0001, 0010, 0100, 1000, 0001. No requester is granted twice in a row.
- len 0: `req` = 4'b0010, len 0 → `grant` = 4'b0010 for 1 cycle, `done` = 4'b0010, `gen_start` never rises.
- Timeout: `TIMEOUT` = 20, len 2, one pulse then silence → `err` = 4'b0001 exactly 20 cycles after that edge, followed by GAP and IDLE.
- Abort and race:
  - Drop `req[3]` mid-burst → `err` = 4'b1000 the next cycle.
  - Separately, final edge in the same cycle as `req` drop → `done`, not `err`.
  - Separately, `rst_n` pulsed mid-burst → no strobe, outputs return to 0.
